// File: rtl/mpc_pkg.sv
// rtl/mpc_pkg.sv - shared types and defaults for the constraint-vector loader
package mpc_pkg;

  localparam int DATA_WIDTH     = 21;
  localparam int ADDR_WIDTH     = 3;
  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_PERIOD = 2;

  typedef logic [DATA_WIDTH-1:0] bound_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2
  } loader_state_e;

  // Counter width for n entries; never below one bit so n == 1 still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mpc_table_ram_1w1r.sv
// rtl/mpc_table_ram_1w1r.sv - simple dual-port table, sync write, registered read-first read
module mpc_table_ram_1w1r
  import mpc_pkg::*;
#(
  parameter int DataWidth    = DATA_WIDTH,
  parameter int AddressWidth = ADDR_WIDTH,
  parameter int Depth        = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AddressWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0]    wr_data,
  input  logic                    rd_en,
  input  logic [AddressWidth-1:0] rd_addr,
  output logic [DataWidth-1:0]    rd_data
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rd_data_q;
  logic [DataWidth-1:0] rd_data_d;

  // Contents are deliberately left unreset; consumers qualify reads with table_valid.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < Depth)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = (int'(rd_addr) < Depth) ? mem_q[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mpc_constraint_vec_loader.sv
// rtl/mpc_constraint_vec_loader.sv - streams Period bound words and replicates them into the d-vector table
module mpc_constraint_vec_loader
  import mpc_pkg::*;
#(
  parameter int DataWidth    = DATA_WIDTH,
  parameter int AddressWidth = ADDR_WIDTH,
  parameter int AddressRange = DEFAULT_DEPTH,
  parameter int Period       = DEFAULT_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DataWidth-1:0]    s_data,
  input  logic                    s_last,
  output logic                    busy,
  output logic                    table_valid,
  output logic                    done,
  output logic                    err,
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  output logic [DataWidth-1:0]    q0
);

  localparam int WIW = idx_width(Period);

  loader_state_e        state_q, state_d;
  logic [WIW-1:0]       widx_q, widx_d;
  logic [WIW-1:0]       sidx_q, sidx_d;
  logic [AddressWidth-1:0] waddr_q, waddr_d;
  logic [DataWidth-1:0] shadow_q [Period];
  logic [DataWidth-1:0] shadow_d [Period];
  logic                 table_valid_q, table_valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic last_word;
  logic sidx_wrap;
  logic fill_last;

  assign last_word = (widx_q == WIW'(Period - 1));
  assign sidx_wrap = (sidx_q == WIW'(Period - 1));
  assign fill_last = (waddr_q == AddressWidth'(AddressRange - 1));

  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    sidx_d        = sidx_q;
    waddr_d       = waddr_q;
    shadow_d      = shadow_q;
    table_valid_d = table_valid_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_LOAD;
          widx_d        = '0;
          table_valid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          shadow_d[widx_q] = s_data;
          widx_d           = widx_q + WIW'(1);
          // A load is well formed only when s_last lands exactly on word Period-1.
          if (last_word && s_last) begin
            state_d = ST_FILL;
            waddr_d = '0;
            sidx_d  = '0;
          end else if (last_word || s_last) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_FILL: begin
        waddr_d = waddr_q + AddressWidth'(1);
        sidx_d  = sidx_wrap ? '0 : sidx_q + WIW'(1);
        if (fill_last) begin
          state_d       = ST_IDLE;
          table_valid_d = 1'b1;
          done_d        = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      widx_q        <= '0;
      sidx_q        <= '0;
      waddr_q       <= '0;
      shadow_q      <= '{default: '0};
      table_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      sidx_q        <= sidx_d;
      waddr_q       <= waddr_d;
      shadow_q      <= shadow_d;
      table_valid_q <= table_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign s_ready     = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign table_valid = table_valid_q;
  assign done        = done_q;
  assign err         = err_q;

  mpc_table_ram_1w1r #(
    .DataWidth   (DataWidth),
    .AddressWidth(AddressWidth),
    .Depth       (AddressRange)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (state_q == ST_FILL),
    .wr_addr(waddr_q),
    .wr_data(shadow_q[sidx_q]),
    .rd_en  (ce0),
    .rd_addr(address0),
    .rd_data(q0)
  );

endmodule

// File: tb/tb_mpc_constraint_vec_loader.sv
// tb/tb_mpc_constraint_vec_loader.sv - scoreboard bench for the constraint-vector loader
module tb_mpc_constraint_vec_loader;

  localparam int DW = 21;
  localparam int AW = 3;
  localparam int R  = 8;
  localparam int P  = 2;
  localparam longint NEVER = 64'h7fff_ffff_ffff;

  typedef logic [DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  word_t         s_data = '0;
  logic          ce0 = 1'b0;
  logic [AW-1:0] address0 = '0;
  logic          s_ready, busy, table_valid, done, err;
  word_t         q0;

  mpc_constraint_vec_loader #(
    .DataWidth(DW), .AddressWidth(AW), .AddressRange(R), .Period(P)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .busy(busy), .table_valid(table_valid),
    .done(done), .err(err), .address0(address0), .ce0(ce0), .q0(q0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rd_flag = 1'b0;
  always @(posedge clk) rd_flag <= ce0 & reset;

  int checks = 0;
  int failures = 0;
  word_t rdq[$];
  int donq[$];
  int errq[$];
  word_t hold_exp = '0;

  // Reference table: for each entry the value before and after the most recent fill,
  // and the clock edge at which that fill writes it.
  word_t  m_old [R];
  word_t  m_new [R];
  bit     k_old [R];
  bit     k_new [R];
  longint m_wt  [R];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit exp_rd(input int a, input longint t, output word_t v);
    if (a >= R) begin
      v = '0;
      return 1'b1;
    end
    if (t > m_wt[a]) begin
      v = m_new[a];
      return k_new[a];
    end
    v = m_old[a];
    return k_old[a];
  endfunction

  function automatic void commit(input word_t w [P], input int el);
    for (int a = 0; a < R; a++) begin
      if (m_wt[a] != NEVER) begin
        m_old[a] = m_new[a];
        k_old[a] = k_new[a];
      end
      m_new[a] = w[a % P];
      k_new[a] = 1'b1;
      m_wt[a]  = longint'(el + 1 + a);
    end
  endfunction

  function automatic void model_reset(input int t0);
    for (int a = 0; a < R; a++) begin
      if (m_wt[a] > longint'(t0)) m_wt[a] = NEVER;
    end
  endfunction

  always @(negedge clk) begin
    word_t e;
    if (!reset) begin
      hold_exp = '0;
    end else begin
      if (rd_flag) begin
        if (rdq.size() == 0) begin
          checks++; failures++;
          $display("FAIL read_unexpected actual=%0h expected=none cycle=%0d", q0, cyc);
        end else begin
          e = rdq.pop_front();
          chk("read_q0", q0, e);
          hold_exp = e;
        end
      end else begin
        chk("hold_q0", q0, hold_exp);
      end
      if (done) begin
        if (donq.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected actual=%0d expected=none", cyc);
        end else chk("done_cycle", cyc, donq.pop_front());
      end
      if (err) begin
        if (errq.size() == 0) begin
          checks++; failures++;
          $display("FAIL err_unexpected actual=%0d expected=none", cyc);
        end else chk("err_cycle", cyc, errq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ce0 = 1'b0;
  endtask

  task automatic rd(input bit en, input int a);
    word_t v;
    bit known;
    known = en ? exp_rd(a, longint'(cyc + 1), v) : 1'b0;
    if (en && known) begin
      ce0 = 1'b1;
      address0 = a[AW-1:0];
      rdq.push_back(v);
    end else begin
      ce0 = 1'b0;
      address0 = AW'($urandom);
    end
  endtask

  task automatic idle(input int n, input bit reads);
    for (int i = 0; i < n; i++) begin
      rd(reads && ($urandom_range(0, 2) != 0), $urandom_range(0, R - 1));
      step();
    end
  endtask

  task automatic do_reset(input int n);
    ce0 = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    reset = 1'b0;
    model_reset(cyc);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_table_valid", table_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_q0", q0, 0);
    repeat (n) step();
    reset = 1'b1;
  endtask

  task automatic do_load(input word_t w [P], input bit use_pat, input logic [7:0] pat,
                         input int err_at, input int abort_at, input bit rf_dir, input bit poke);
    int k, i, pc, stalls, el;
    bit v;
    start = 1'b1;
    rd($urandom_range(0, 1), $urandom_range(0, R - 1));
    k = cyc;
    step();
    start = 1'b0;
    chk("start_tv_cleared", table_valid, 0);
    chk("load_busy", busy, 1);
    chk("load_s_ready", s_ready, 1);
    i = 0; pc = 0; stalls = 0;
    while (i < P) begin
      v = use_pat ? ((pc < 8) ? pat[pc] : 1'b1) : ($urandom_range(0, 3) != 0);
      pc++;
      s_valid = v;
      s_data  = v ? w[i] : word_t'($urandom);
      s_last  = v && ((i == P - 1) != (i == err_at));
      start   = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      rd($urandom_range(0, 1), $urandom_range(0, R - 1));
      step();
      start = 1'b0;
      if (v) begin
        if (i == err_at) begin
          s_valid = 1'b0; s_last = 1'b0;
          errq.push_back(cyc);
          chk("err_busy", busy, 0);
          chk("err_s_ready", s_ready, 0);
          chk("err_table_valid", table_valid, 0);
          return;
        end
        i++;
      end else begin
        stalls++;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    el = cyc;
    commit(w, el);
    chk("fill_busy", busy, 1);
    chk("fill_s_ready", s_ready, 0);
    if (abort_at < 0) donq.push_back(k + 1 + P + stalls + R);
    for (int j = 0; j < R; j++) begin
      if (abort_at == j) begin
        ce0 = 1'b0; start = 1'b0;
        reset = 1'b0;
        model_reset(cyc);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_table_valid", table_valid, 0);
        chk("abort_q0", q0, 0);
        repeat (3) step();
        reset = 1'b1;
        return;
      end
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (abort_at >= 0) rd(1'b0, 0);
      else if (rf_dir && (j == 3 || j == 4)) rd(1'b1, 3);
      else rd($urandom_range(0, 1), $urandom_range(0, R - 1));
      step();
    end
    start = 1'b0;
    chk("end_table_valid", table_valid, 1);
    chk("end_busy", busy, 0);
  endtask

  function automatic void rand_words(output word_t w [P]);
    for (int i = 0; i < P; i++) w[i] = word_t'($urandom);
  endfunction

  initial begin
    word_t w [P];
    for (int a = 0; a < R; a++) begin
      m_wt[a] = NEVER; k_old[a] = 1'b0; k_new[a] = 1'b0;
      m_old[a] = '0; m_new[a] = '0;
    end
    do_reset(3);
    idle(2, 1'b0);

    w[0] = 21'h160000; w[1] = 21'h19B781;
    do_load(w, 1'b1, 8'hFF, -1, -1, 1'b0, 1'b0);
    for (int a = 0; a < R; a++) begin
      rd(1'b1, a);
      step();
    end
    idle(3, 1'b1);

    do_load(w, 1'b1, 8'b0000_1001, -1, -1, 1'b0, 1'b0);
    for (int a = 0; a < R; a++) begin
      rd(1'b1, a);
      step();
    end

    rand_words(w);
    do_load(w, 1'b1, 8'hFF, 0, -1, 1'b0, 1'b0);
    idle(6, 1'b1);
    rand_words(w);
    do_load(w, 1'b0, 8'h00, P - 1, -1, 1'b0, 1'b0);
    idle(4, 1'b1);

    rand_words(w);
    do_load(w, 1'b0, 8'h00, -1, -1, 1'b0, 1'b0);
    idle(2, 1'b1);
    rand_words(w);
    do_load(w, 1'b0, 8'h00, -1, 3, 1'b0, 1'b0);
    idle(4, 1'b1);
    w[0] = 21'h000001; w[1] = 21'h000002;
    do_load(w, 1'b1, 8'hFF, -1, -1, 1'b0, 1'b0);
    for (int a = 0; a < R; a++) begin
      rd(1'b1, a);
      step();
    end

    rand_words(w);
    do_load(w, 1'b1, 8'hFF, -1, -1, 1'b1, 1'b0);
    idle(3, 1'b1);

    rand_words(w);
    do_load(w, 1'b0, 8'h00, -1, -1, 1'b0, 1'b1);
    idle(6, 1'b0);

    repeat (12) begin
      rand_words(w);
      do_load(w, 1'b0, 8'h00, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, P - 1)) : -1,
              -1, 1'b0, 1'($urandom_range(0, 1)));
      idle($urandom_range(1, 4), 1'b1);
    end
    idle(4, 1'b0);

    chk("pending_reads", rdq.size(), 0);
    chk("pending_done", donq.size(), 0);
    chk("pending_err", errq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
